key_match_scanner: RTL and testbench
====================================

# key_match_scanner

Streaming word scanner that consumes a valid/ready stream of N-bit words, compares each word to a programmed key, and reports a per-packet result. The result gives whether any word matched, the zero-based index of the first match, and the total match count. It sits downstream of a data source and upstream of control logic. It is the sequential consumer built around the team's structural N-bit equality comparator.

## Interface
Parameters:
- N, 32, data and key width in bits
- IDX_W, 16, width of beat index and match counters

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- key_load  in  1  capture key_in into key register this edge
- key_in  in  N  new key value
- in_valid  in  1  input beat present
- in_ready  out  1  scanner accepts beat this cycle
- in_data  in  N  input word
- in_last  in  1  final beat of packet
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- res_found  out  1  at least one match in packet
- res_index  out  IDX_W  beat index of first match; 0 when res_found=0
- res_count  out  IDX_W  number of matching beats, saturating

## Operation
- Beat accepted when in_valid && in_ready.
- match = (in_data == key_r), computed by a comparator_eq instance.
- States:
  - SCAN: in_ready=1; res_valid=0.
  - REPORT: in_ready=0; res_valid=1; result outputs held stable.
- Transitions:
  - SCAN -> REPORT on an accepted beat with in_last=1.
  - REPORT -> SCAN on res_ready=1.
- Per accepted beat in SCAN:
  - if match and no prior match in packet: found_r<=1, first_r<=beat_r
  - if match: count_r<=count_r+1, saturating at 2^IDX_W-1
  - beat_r<=beat_r+1, saturating at 2^IDX_W-1; beats beyond saturation report index 2^IDX_W-1 if first match
- The in_last beat is itself compared and counted before REPORT.
- On leaving REPORT: beat_r, count_r, found_r, first_r cleared to 0.
- key_load:
  - Accepted in any state; key_r updates at the edge.
  - A beat accepted on the same edge compares against the old key_r.
- Single-beat packet (in_last on first beat) is legal.

## Timing
- Reset values:
  - in_ready=1, res_valid=0, res_found=0, res_index=0, res_count=0
  - key_r=0, state=SCAN
- Reset mid-packet or during REPORT discards all packet state.
- Result latency: res_valid rises the cycle after the in_last beat is accepted.
- Throughput: one beat per cycle in SCAN.
- One bubble cycle minimum per packet: REPORT lasts at least one cycle, and in_ready=0 while in REPORT.
- res_valid, once high, stays high with stable outputs until the res_ready handshake. The handshake completes on the edge where res_valid && res_ready.
- in_ready is a registered function of state, with no combinational path from res_ready.

## Configuration
- KEY_MASK_EN defined:
  - Adds input key_mask (N bits), captured into mask_r alongside key_in on key_load; reset value all-ones.
  - match = ((in_data ^ key_r) & mask_r) == 0.
  - Mask bit 0 means don't-care.
- KEY_MASK_EN undefined: no key_mask port; exact full-width equality.

## Structure
- Package key_match_pkg: state enum typedef (S_SCAN, S_REPORT).
- Sub-module comparator_eq, parameterised N, instanced once for the match term.
- With KEY_MASK_EN, both comparator_eq operands are pre-masked with mask_r.

## Test plan
- Reset, then key_load 0xDEADBEEF; stream 5 beats 0,0xDEADBEEF,1,0xDEADBEEF,2(last) -> res_valid next cycle, found=1, index=1, count=2; held until res_ready.
- Stream 3 non-matching beats (last on third) -> found=0, index=0, count=0.
- Single beat 0xDEADBEEF with last; hold res_ready=0 for 4 cycles -> in_ready=0 and outputs stable throughout; after res_ready, in_ready=1 and counters cleared.
- key_load of 0x5 on the same edge as an accepted beat 0x5 (old key 0x7) -> that beat not matched; next beat 0x5 matched.
- IDX_W=4, 20 matching beats -> count=15 saturated, index=0.
- Assert rst during REPORT -> next cycle res_valid=0, in_ready=1; new packet reports fresh counts. With KEY_MASK_EN, mask 0xFFFF0000, key 0x12340000, beat 0x1234ABCD -> match.

Source files
------------

// File: rtl/key_match_pkg.sv
// key_match_pkg: shared state encoding for key_match_scanner.
package key_match_pkg;
  typedef enum logic {S_SCAN, S_REPORT} state_t;
endpackage

// File: rtl/comparator_eq.sv
// comparator_eq: structural N-bit equality, one xor per bit folded by a nor-reduce.
module comparator_eq #(
  parameter int N = 32
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic         o_eq
);
  assign o_eq = ~|(i_a ^ i_b);
endmodule

// File: rtl/key_match_scanner.sv
// key_match_scanner: per-packet key search over a valid/ready word stream.
// Define KEY_MASK_EN to add a key_mask port where mask bit 0 means don't-care.
module key_match_scanner
  import key_match_pkg::*;
#(
  parameter int N     = 32,
  parameter int IDX_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_load,
  input  logic [N-1:0]     key_in,
`ifdef KEY_MASK_EN
  input  logic [N-1:0]     key_mask,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_found,
  output logic [IDX_W-1:0] res_index,
  output logic [IDX_W-1:0] res_count
);
  localparam logic [IDX_W-1:0] MAX = '1;
  state_t           r_state, w_next;
  logic [N-1:0]     r_key, w_a, w_b;
  logic [IDX_W-1:0] r_beat, r_count, r_first;
  logic             r_found, w_match, w_accept, w_done;
`ifdef KEY_MASK_EN
  logic [N-1:0]     r_mask;
  assign w_a = in_data & r_mask;
  assign w_b = r_key & r_mask;
`else
  assign w_a = in_data;
  assign w_b = r_key;
`endif
  comparator_eq #(.N(N)) u_cmp (.i_a(w_a), .i_b(w_b), .o_eq(w_match));
  assign in_ready  = (r_state == S_SCAN);
  assign res_valid = (r_state == S_REPORT);
  assign w_accept  = in_valid && in_ready;
  assign w_done    = res_valid && res_ready;
  assign res_found = r_found;
  assign res_index = r_first;
  assign res_count = r_count;
  always_comb begin
    w_next = r_state;
    if (w_accept && in_last) w_next = S_REPORT;
    if (w_done) w_next = S_SCAN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_SCAN;
      r_key   <= '0;
`ifdef KEY_MASK_EN
      r_mask  <= '1;
`endif
      r_beat  <= '0;
      r_count <= '0;
      r_first <= '0;
      r_found <= 1'b0;
    end else begin
      r_state <= w_next;
      if (key_load) begin
        r_key  <= key_in;
`ifdef KEY_MASK_EN
        r_mask <= key_mask;
`endif
      end
      if (w_done) begin
        r_beat  <= '0;
        r_count <= '0;
        r_first <= '0;
        r_found <= 1'b0;
      end else if (w_accept) begin
        r_beat <= (r_beat == MAX) ? MAX : r_beat + 1'b1;
        if (w_match) begin
          r_count <= (r_count == MAX) ? MAX : r_count + 1'b1;
          if (!r_found) begin
            r_found <= 1'b1;
            r_first <= r_beat;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_key_match_scanner.sv
// tb_key_match_scanner: directed table plus corner sequences on a 16-bit-index and a 4-bit-index instance.
module tb_key_match_scanner;
  logic        clk = 1'b0;
  logic        rst, key_load, in_valid, in_last, res_ready;
  logic [31:0] key_in, in_data, key_mask;
  logic        ir_m, rv_m, f_m, ir_s, rv_s, f_s;
  logic [15:0] idx_m, cnt_m;
  logic [3:0]  idx_s, cnt_s;
  int          errors = 0;
  int          checks = 0;
  always #5 clk = ~clk;
  key_match_scanner #(.N(32), .IDX_W(16)) u_main (
    .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in),
`ifdef KEY_MASK_EN
    .key_mask(key_mask),
`endif
    .in_valid(in_valid), .in_ready(ir_m), .in_data(in_data), .in_last(in_last),
    .res_valid(rv_m), .res_ready(res_ready), .res_found(f_m), .res_index(idx_m), .res_count(cnt_m)
  );
  key_match_scanner #(.N(32), .IDX_W(4)) u_small (
    .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in),
`ifdef KEY_MASK_EN
    .key_mask(key_mask),
`endif
    .in_valid(in_valid), .in_ready(ir_s), .in_data(in_data), .in_last(in_last),
    .res_valid(rv_s), .res_ready(res_ready), .res_found(f_s), .res_index(idx_s), .res_count(cnt_s)
  );
  typedef struct packed {
    logic        kl;
    logic [31:0] key;
    logic        v;
    logic [31:0] d;
    logic        last;
    logic        rr;
    logic        ir;
    logic        rv;
    logic        f;
    logic [15:0] idx;
    logic [15:0] cnt;
  } vec_t;
  vec_t tbl [22];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask
  task automatic chk_hs(input string nm, input logic ir, input logic rv);
    chk({nm, ".in_ready"}, {31'd0, ir_m}, {31'd0, ir});
    chk({nm, ".res_valid"}, {31'd0, rv_m}, {31'd0, rv});
    chk({nm, ".s.in_ready"}, {31'd0, ir_s}, {31'd0, ir});
    chk({nm, ".s.res_valid"}, {31'd0, rv_s}, {31'd0, rv});
  endtask
  task automatic chk_res(input string nm, input logic f, input logic [15:0] im, input logic [15:0] cm,
                         input logic [3:0] is, input logic [3:0] cs);
    chk({nm, ".found"}, {31'd0, f_m}, {31'd0, f});
    chk({nm, ".index"}, {16'd0, idx_m}, {16'd0, im});
    chk({nm, ".count"}, {16'd0, cnt_m}, {16'd0, cm});
    chk({nm, ".s.found"}, {31'd0, f_s}, {31'd0, f});
    chk({nm, ".s.index"}, {28'd0, idx_s}, {28'd0, is});
    chk({nm, ".s.count"}, {28'd0, cnt_s}, {28'd0, cs});
  endtask
  task automatic step(input logic k, input logic [31:0] kv, input logic v, input logic [31:0] d,
                      input logic l, input logic r);
    key_load = k; key_in = kv; in_valid = v; in_data = d; in_last = l; res_ready = r;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1; key_load = 1'b0; key_in = '0; in_valid = 1'b0; in_data = '0;
    in_last = 1'b0; res_ready = 1'b0; key_mask = '1;
    repeat (2) @(posedge clk);
    #1;
    chk_hs("reset", 1'b1, 1'b0);
    chk_res("reset", 1'b0, 16'd0, 16'd0, 4'd0, 4'd0);
    rst = 1'b0;
    tbl[0]  = '{1'b1, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[1]  = '{1'b0, 32'h0,        1'b1, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[2]  = '{1'b0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[3]  = '{1'b0, 32'h0,        1'b1, 32'h1,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[4]  = '{1'b0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[5]  = '{1'b0, 32'h0,        1'b1, 32'h2,        1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1, 16'd2};
    tbl[6]  = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1, 16'd2};
    tbl[7]  = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[8]  = '{1'b0, 32'h0,        1'b1, 32'h3,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[9]  = '{1'b0, 32'h0,        1'b1, 32'h4,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[10] = '{1'b0, 32'h0,        1'b1, 32'h5,        1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0};
    tbl[11] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[12] = '{1'b0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0, 16'd1};
    tbl[13] = '{1'b0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0, 16'd1};
    tbl[14] = '{1'b0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0, 16'd1};
    tbl[15] = '{1'b0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0, 16'd1};
    tbl[16] = '{1'b0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0, 16'd1};
    tbl[17] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[18] = '{1'b1, 32'h7,        1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[19] = '{1'b1, 32'h5,        1'b1, 32'h5,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[20] = '{1'b0, 32'h0,        1'b1, 32'h5,        1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1, 16'd1};
    tbl[21] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0};
    for (int i = 0; i < 22; i++) begin
      step(tbl[i].kl, tbl[i].key, tbl[i].v, tbl[i].d, tbl[i].last, tbl[i].rr);
      chk_hs($sformatf("row%0d", i), tbl[i].ir, tbl[i].rv);
      if (tbl[i].rv)
        chk_res($sformatf("row%0d", i), tbl[i].f, tbl[i].idx, tbl[i].cnt, tbl[i].idx[3:0], tbl[i].cnt[3:0]);
    end
    for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b1, 32'h5, i == 19, 1'b0);
    chk_hs("sat_cnt", 1'b0, 1'b1);
    chk_res("sat_cnt", 1'b1, 16'd0, 16'd20, 4'd0, 4'd15);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk_hs("sat_cnt_done", 1'b1, 1'b0);
    for (int i = 0; i < 17; i++) step(1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 32'h5, 1'b1, 1'b0);
    chk_hs("sat_idx", 1'b0, 1'b1);
    chk_res("sat_idx", 1'b1, 16'd17, 16'd1, 4'd15, 4'd1);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 32'h5, 1'b1, 1'b0);
    chk_hs("pre_rst", 1'b0, 1'b1);
    rst = 1'b1;
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    chk_hs("rst_report", 1'b1, 1'b0);
    chk_res("rst_report", 1'b0, 16'd0, 16'd0, 4'd0, 4'd0);
    step(1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0);
    chk_hs("post_rst", 1'b0, 1'b1);
    chk_res("post_rst", 1'b1, 16'd0, 16'd2, 4'd0, 4'd2);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk_hs("post_rst_done", 1'b1, 1'b0);
`ifdef KEY_MASK_EN
    key_mask = 32'hFFFF0000;
    step(1'b1, 32'h12340000, 1'b0, 32'h0, 1'b0, 1'b0);
    key_mask = '1;
    step(1'b0, 32'h0, 1'b1, 32'h1235ABCD, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 32'h1234ABCD, 1'b1, 1'b0);
    chk_hs("mask", 1'b0, 1'b1);
    chk_res("mask", 1'b1, 16'd1, 16'd1, 4'd1, 4'd1);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
